instr_dispatch: RTL

INSTR_DISPATCH -- requirements
Module: instr_dispatch

---
 rtl/instr_dispatch.sv | 106 ++++++++++
 1 files changed

// File: rtl/instr_dispatch.sv
// instr_dispatch: walks a wrapped index range of an instruction register and
// issues each fetched entry downstream over a valid/ready handshake.
package instr_register_pkg;
    localparam int DEPTH = 16;
    typedef logic [$clog2(DEPTH)-1:0] index_t;
    typedef logic [31:0] operand_t;
    typedef enum logic [2:0] {ZERO, PASSA, PASSB, ADD, SUB, MULT, DIV, MOD} opcode_t;
    typedef struct packed {
        opcode_t  opc;
        operand_t op_a;
        operand_t op_b;
    } instruction_t;
endpackage

module instr_dispatch
    import instr_register_pkg::*;
#(
    parameter bit SKIP_ZERO = 1'b0
) (
    input  logic                  clk,
    input  logic                  reset_en,
    input  logic                  start,
    input  index_t                first_index,
    input  index_t                last_index,
    output index_t                read_index,
    input  instruction_t          instruction,
    output logic                  out_valid,
    input  logic                  out_ready,
    output opcode_t               out_opcode,
    output operand_t              out_op_a,
    output operand_t              out_op_b,
    output index_t                out_index,
    output logic                  busy,
    output logic                  done,
    output logic [$bits(index_t):0] issued_count
);
    typedef enum logic [2:0] {IDLE, REQ, CAPTURE, ISSUE, DONE} state_t;

    state_t r_state, w_nstate;
    index_t r_ptr, r_last, r_idx, w_next;
    opcode_t r_opc;
    operand_t r_a, r_b;
    logic [$bits(index_t):0] r_count;
    logic w_hs, w_last, w_skip;

    assign w_hs   = r_state == ISSUE && out_ready;
    assign w_last = r_ptr == r_last;
    assign w_skip = SKIP_ZERO && instruction.opc == ZERO;
    assign w_next = (r_ptr == index_t'(DEPTH-1)) ? '0 : r_ptr + 1'b1;

    always_ff @(posedge clk) begin
        if (reset_en) r_state <= IDLE;
        else          r_state <= w_nstate;
    end

    always_comb begin
        w_nstate = r_state;
        case (r_state)
            IDLE:    w_nstate = start ? REQ : IDLE;
            REQ:     w_nstate = CAPTURE;
            CAPTURE: w_nstate = !w_skip ? ISSUE : (w_last ? DONE : REQ);
            ISSUE:   w_nstate = !w_hs ? ISSUE : (w_last ? DONE : REQ);
            default: w_nstate = IDLE;
        endcase
    end

    always_comb begin
        out_valid = r_state == ISSUE;
        busy      = r_state != IDLE;
        done      = r_state == DONE;
    end

    // The pointer only moves on entry to REQ, so it doubles as the held read address.
    always_ff @(posedge clk) begin
        if (reset_en) begin
            r_ptr   <= '0;
            r_last  <= '0;
            r_idx   <= '0;
            r_opc   <= ZERO;
            r_a     <= '0;
            r_b     <= '0;
            r_count <= '0;
        end else begin
            if (r_state == IDLE && start) begin
                r_ptr   <= first_index;
                r_last  <= last_index;
                r_count <= '0;
            end
            if (r_state == CAPTURE) begin
                r_opc <= instruction.opc;
                r_a   <= instruction.op_a;
                r_b   <= instruction.op_b;
                r_idx <= r_ptr;
            end
            if (((r_state == CAPTURE && w_skip) || w_hs) && !w_last) r_ptr <= w_next;
            if (w_hs) r_count <= r_count + 1'b1;
        end
    end

    assign read_index   = r_ptr;
    assign out_opcode   = r_opc;
    assign out_op_a     = r_a;
    assign out_op_b     = r_b;
    assign out_index    = r_idx;
    assign issued_count = r_count;
endmodule
